// File: rtl/dcache_miss_handler_if.sv
// dcache_miss_handler_if: AXI4 master bus used by the miss handler to move whole cache blocks
interface dcache_miss_handler_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wlast, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arlen, arsize, arburst, input arready,
    input rvalid, rdata, rresp, rlast, output rready
  );
  modport slave (
    input awvalid, awaddr, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wlast, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/dcache_miss_handler.sv
// dcache_miss_handler: writes back a dirty victim and refills the missing block over AXI4
module dcache_miss_handler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_req,
  input  logic                   i_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [ADDR_WIDTH-1:0]  i_addr_fill,
  input  logic [BLOCK_WIDTH-1:0] i_wb_block,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_fill_block,
  output logic                   o_busy,
  output logic                   o_error,
  dcache_miss_handler_if.master  axi
);
  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FILL} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_wb_q, addr_wb_d;
  logic [ADDR_WIDTH-1:0]  addr_fill_q, addr_fill_d;
  logic [BLOCK_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [BLOCK_WIDTH-1:0] fill_q, fill_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  // state, captured request, beat counter, buffers and sticky error flag
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q     <= IDLE;
      addr_wb_q   <= '0;
      addr_fill_q <= '0;
      wbuf_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_wb_q   <= addr_wb_d;
      addr_fill_q <= addr_fill_d;
      wbuf_q      <= wbuf_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end
  // sequencing: optional write-back burst, refill burst, then one fill cycle; inputs only sampled in IDLE
  always_comb begin
    state_d     = state_q;
    addr_wb_d   = addr_wb_q;
    addr_fill_d = addr_fill_q;
    wbuf_d      = wbuf_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: if (i_req) begin
        state_d     = i_dirty ? AW : AR;
        wbuf_d      = i_wb_block;
        addr_wb_d   = i_addr_wb & MASK;
        addr_fill_d = i_addr_fill & MASK;
        cnt_d       = '0;
        err_d       = 1'b0;
      end
      AW: state_d = axi.awready ? W : AW;
      W: if (axi.wready) begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? B : W;
      end
      B: if (axi.bvalid) begin
        err_d   = err_q | (axi.bresp != 2'b00);
        state_d = AR;
      end
      AR: begin
        cnt_d   = '0;
        state_d = axi.arready ? R : AR;
      end
      R: if (axi.rvalid) begin
        fill_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = axi.rdata;
        cnt_d   = cnt_q + CW'(1);
        err_d   = err_q | (axi.rresp != 2'b00) | (axi.rlast != (cnt_q == LAST));
        state_d = cnt_q == LAST ? FILL : R;
      end
      default: state_d = IDLE;
    endcase
  end
  // bus and cache outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    axi.awvalid  = state_q == AW;
    axi.awaddr   = addr_wb_q;
    axi.awlen    = state_q == AW ? 8'(BEATS - 1) : 8'd0;
    axi.awsize   = 3'($clog2(DATA_WIDTH / 8));
    axi.awburst  = 2'b01;
    axi.wvalid   = state_q == W;
    axi.wdata    = wbuf_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
    axi.wlast    = state_q == W && cnt_q == LAST;
    axi.bready   = state_q == B;
    axi.arvalid  = state_q == AR;
    axi.araddr   = addr_fill_q;
    axi.arlen    = state_q == AR ? 8'(BEATS - 1) : 8'd0;
    axi.arsize   = 3'($clog2(DATA_WIDTH / 8));
    axi.arburst  = 2'b01;
    axi.rready   = state_q == R;
    o_block_we   = state_q == FILL;
    o_error      = state_q == FILL && err_q;
    o_busy       = state_q != IDLE;
    o_fill_block = fill_q;
  end
endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb_dcache_miss_handler: randomized AXI slave with a scoreboard checking bursts and refills against a block-level model
module tb_dcache_miss_handler;
  localparam int AW = 64, DW = 64, BW = 512, BEATS = 8;
  localparam logic [AW-1:0] MASK = ~64'h3f;
  logic clk = 0, arst = 1, req = 0, dirty = 0;
  logic [AW-1:0] addr_wb = '0, addr_fill = '0;
  logic [BW-1:0] wb_block = '0, fill_block;
  logic block_we, busy, error;
  dcache_miss_handler_if axi();
  dcache_miss_handler dut (
    .i_clk(clk), .i_arst(arst), .i_req(req), .i_dirty(dirty),
    .i_addr_wb(addr_wb), .i_addr_fill(addr_fill), .i_wb_block(wb_block),
    .o_block_we(block_we), .o_fill_block(fill_block), .o_busy(busy), .o_error(error),
    .axi(axi)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [AW-1:0] q_aw[$], q_ar[$];
  logic [DW-1:0] q_w[$];
  logic          q_wl[$], q_err[$];
  logic [BW-1:0] q_fill[$];
  logic [BW-1:0] cur_rblk = '0;
  logic [1:0]    cur_bresp = '0;
  int            cur_rlast = BEATS - 1, cur_rresp = -1;
  bit            stall = 0;
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected by scoreboard", nm);
  endtask
  function automatic logic rnd();
    return !stall || ($urandom_range(0, 2) != 0);
  endfunction
  // AXI slave: random ready/valid when stalling, returns the current refill block beat by beat
  bit b_pend = 0, r_pend = 0, p_wl_hs = 0, p_b_hs = 0, p_ar_hs = 0, p_r_hs = 0;
  int r_beat = 0;
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.arready = 0;
    axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
  end
  always @(negedge clk) begin
    if (!arst) begin
      b_pend = 0; r_pend = 0; r_beat = 0;
    end else begin
      if (p_wl_hs) b_pend = 1;
      if (p_b_hs) b_pend = 0;
      if (p_ar_hs) begin r_pend = 1; r_beat = 0; end
      if (p_r_hs) begin r_beat++; if (r_beat == BEATS) r_pend = 0; end
    end
    axi.awready = rnd();
    axi.wready  = rnd();
    axi.arready = rnd();
    axi.bvalid  = b_pend && (axi.bvalid || rnd());
    axi.bresp   = cur_bresp;
    axi.rvalid  = r_pend && ((axi.rvalid && !p_r_hs) || rnd());
    axi.rdata   = (r_pend && r_beat < BEATS) ? cur_rblk[r_beat*DW +: DW] : '0;
    axi.rlast   = r_pend && r_beat == cur_rlast;
    axi.rresp   = (r_pend && r_beat == cur_rresp) ? 2'd2 : 2'd0;
    p_wl_hs = axi.wvalid && axi.wready && axi.wlast;
    p_b_hs  = axi.bvalid && axi.bready;
    p_ar_hs = axi.arvalid && axi.arready;
    p_r_hs  = axi.rvalid && axi.rready;
  end
  // monitor: pops the scoreboard on every handshake / block write and checks stalled channels stay stable
  logic pv_aw = 0, pv_w = 0, pv_ar = 0, pwl = 0;
  logic [AW-1:0] pa_aw = '0, pa_ar = '0;
  logic [DW-1:0] pw = '0;
  always @(negedge clk) begin
    #2;
    if (!arst) begin
      pv_aw = 0; pv_w = 0; pv_ar = 0;
    end else begin
      if (pv_aw) chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, pa_aw});
      if (pv_w) chk("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, pwl, pw});
      if (pv_ar) chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, pa_ar});
      if (axi.awvalid && axi.awready) begin
        if (q_aw.size() == 0) fail("aw_burst");
        else begin chk("awaddr", axi.awaddr, q_aw.pop_front()); chk("awlen", axi.awlen, 7); end
      end
      if (axi.wvalid && axi.wready) begin
        if (q_w.size() == 0) fail("w_beat");
        else begin chk("wdata", axi.wdata, q_w.pop_front()); chk("wlast", axi.wlast, q_wl.pop_front()); end
      end
      if (axi.arvalid && axi.arready) begin
        if (q_ar.size() == 0) fail("ar_burst");
        else begin chk("araddr", axi.araddr, q_ar.pop_front()); chk("arlen", axi.arlen, 7); end
      end
      if (block_we) begin
        if (q_fill.size() == 0) fail("block_we");
        else begin chk("fill_block", fill_block, q_fill.pop_front()); chk("error", error, q_err.pop_front()); end
      end else if (error) fail("error_without_we");
      pv_aw = axi.awvalid && !axi.awready; pa_aw = axi.awaddr;
      pv_w  = axi.wvalid && !axi.wready;   pw = axi.wdata; pwl = axi.wlast;
      pv_ar = axi.arvalid && !axi.arready; pa_ar = axi.araddr;
    end
  end
  // reference model: a miss is an aligned write-back of the victim words, an aligned refill, and an error summary
  task automatic expect_txn(input bit d, input logic [AW-1:0] awb, input logic [AW-1:0] af,
                            input logic [BW-1:0] blk, input logic [BW-1:0] rblk,
                            input logic [1:0] br, input int rl, input int rr);
    if (d) begin
      q_aw.push_back(awb & MASK);
      for (int k = 0; k < BEATS; k++) begin
        q_w.push_back(blk[k*DW +: DW]);
        q_wl.push_back(k == BEATS - 1);
      end
    end
    q_ar.push_back(af & MASK);
    q_fill.push_back(rblk);
    q_err.push_back((d && br != 0) || (rr >= 0 && rr < BEATS) || rl != BEATS - 1);
    cur_rblk = rblk; cur_bresp = br; cur_rlast = rl; cur_rresp = rr;
  endtask
  task automatic drive(input bit d, input logic [AW-1:0] awb, input logic [AW-1:0] af, input logic [BW-1:0] blk);
    dirty = d; addr_wb = awb; addr_fill = af; wb_block = blk; req = 1;
  endtask
  task automatic wait_we(input int lat);
    int c = 0;
    do begin @(negedge clk); c++; end while (!block_we && c < 3000);
    if (!block_we) fail("block_we_timeout");
    else if (lat >= 0) chk("latency", c, lat);
  endtask
  task automatic run_txn(input bit d, input logic [AW-1:0] awb, input logic [AW-1:0] af,
                         input logic [BW-1:0] blk, input logic [BW-1:0] rblk,
                         input logic [1:0] br, input int rl, input int rr, input int lat);
    expect_txn(d, awb, af, blk, rblk, br, rl, rr);
    @(negedge clk);
    drive(d, awb, af, blk);
    wait_we(lat);
    req = 0;
  endtask
  task automatic check_idle();
    chk("rst_flags", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready, block_we, busy, error}, 0);
    chk("rst_addr", {axi.awaddr, axi.araddr}, 0);
    chk("rst_len", {axi.awlen, axi.arlen}, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_fill", fill_block, 0);
  endtask
  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction
  initial begin
    logic [BW-1:0] blk, rb;
    #2 arst = 0;
    repeat (3) @(negedge clk);
    check_idle();
    arst = 1;
    for (int k = 0; k < BEATS; k++) rb[k*DW +: DW] = DW'(k + 1);
    run_txn(0, '0, 64'h1234_5678, '0, rb, 0, 7, -1, 10);
    for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = DW'(8'hA0 + k);
    run_txn(1, 64'h8000_00C0, 64'h4000_1010, blk, rand_blk(), 0, 7, -1, 20);
    run_txn(1, 64'h8000_00C0, 64'h4000_2020, rand_blk(), rand_blk(), 2, 7, -1, 20);
    run_txn(0, '0, 64'h4000_3030, '0, rand_blk(), 0, 5, -1, 10);
    rb = rand_blk();
    expect_txn(1, 64'h9000_0047, 64'h9000_1000, blk, rb, 0, 7, -1);
    @(negedge clk);
    drive(1, 64'h9000_0047, 64'h9000_1000, blk);
    repeat (5) @(negedge clk);
    chk("w_beat3", {axi.wvalid, axi.wdata}, {1'b1, blk[3*DW +: DW]});
    arst = 0; req = 0;
    #1 check_idle();
    q_aw.delete(); q_w.delete(); q_wl.delete(); q_ar.delete(); q_fill.delete(); q_err.delete();
    repeat (2) @(negedge clk);
    arst = 1;
    run_txn(0, '0, 64'h2222_3333, '0, rand_blk(), 0, 7, -1, 10);
    rb = rand_blk();
    expect_txn(0, '0, 64'h5555_0100, '0, rb, 0, 7, -1);
    expect_txn(0, '0, 64'h6666_0200, '0, rb, 0, 7, -1);
    @(negedge clk);
    drive(0, '0, 64'h5555_0100, '0);
    @(negedge clk);
    addr_fill = 64'h6666_0200;
    wait_we(9);
    wait_we(11);
    req = 0;
    repeat (15) @(negedge clk);
    chk("idle_after_refills", busy, 0);
    for (int t = 0; t < 40; t++) begin
      bit d;
      int rl, rr;
      logic [1:0] br;
      stall = $urandom_range(0, 1) != 0;
      d  = $urandom_range(0, 1) != 0;
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 7;
      rr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      run_txn(d, {$urandom, $urandom}, {$urandom, $urandom}, rand_blk(), rand_blk(), br, rl, rr,
              stall ? -1 : (d ? 20 : 10));
    end
    stall = 0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q_aw.size() + q_w.size() + q_ar.size() + q_fill.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
